// File: rtl/muldiv_unit_e.sv
// rtl/muldiv_unit_e.sv - iterative RV32M multiply/divide unit for the execute stage
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiply, divides stay iterative.
module muldiv_unit_e #(
    parameter int XLEN        = 32,
    parameter int ITER_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_e,
    input  logic [2:0]      funct3_e,
    input  logic [XLEN-1:0] src_a_e,
    input  logic [XLEN-1:0] src_b_e,
    input  logic            flush_e,
    output logic            stall_e,
    output logic            done_e,
    output logic [XLEN-1:0] result_e
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [4:0]      LAST    = 5'(ITER_CYCLES - 1);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t              state, state_next;
    logic [4:0]          cnt;
    logic [2*XLEN-1:0]   acc;
    logic [XLEN-1:0]     opd_q;
    logic [2:0]          f3_q;
    logic                neg_q, rneg_q;

    logic                sgn_a_en, sgn_b_en, sa, sb;
    logic [XLEN-1:0]     mag_a, mag_b;
    logic                div_zero, div_ovf, special, go_done;
    logic [XLEN-1:0]     special_res, idle_res;
    logic [XLEN:0]       mul_sum, rem_sh, diff;
    logic [2*XLEN-1:0]   mul_next, div_next, step_next, prod_s;
    logic [XLEN-1:0]     quo_s, rem_s, final_res;

    // Sign handling per funct3: MUL/MULH/DIV/REM signed both, MULHSU signed rs1 only
    assign sgn_a_en    = funct3_e[2] ? ~funct3_e[0] : (funct3_e[1:0] != 2'b11);
    assign sgn_b_en    = funct3_e[2] ? ~funct3_e[0] : ~funct3_e[1];
    assign sa          = sgn_a_en & src_a_e[XLEN-1];
    assign sb          = sgn_b_en & src_b_e[XLEN-1];
    assign mag_a       = sa ? -src_a_e : src_a_e;
    assign mag_b       = sb ? -src_b_e : src_b_e;

    assign div_zero    = funct3_e[2] & (src_b_e == '0);
    assign div_ovf     = funct3_e[2] & ~funct3_e[0] & (src_a_e == INT_MIN) & (src_b_e == '1);
    assign special     = div_zero | div_ovf;
    assign special_res = div_zero ? (funct3_e[1] ? src_a_e : '1)
                                  : (funct3_e[1] ? '0 : INT_MIN);

`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     fast_a, fast_b;
    logic signed [2*XLEN-1:0] fast_prod;
    assign fast_a    = {sa, src_a_e};
    assign fast_b    = {sb, src_b_e};
    assign fast_prod = (2*XLEN)'(fast_a) * (2*XLEN)'(fast_b);
    assign go_done   = special | ~funct3_e[2];
    assign idle_res  = special ? special_res
                     : ((funct3_e[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN]);
`else
    assign go_done   = special;
    assign idle_res  = special_res;
`endif

    // One radix-2 step: shift-add for multiply, restoring subtract for divide
    assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opd_q} : '0);
    assign mul_next  = {mul_sum, acc[XLEN-1:1]};
    assign rem_sh    = acc[2*XLEN-1:XLEN-1];
    assign diff      = rem_sh - {1'b0, opd_q};
    assign div_next  = diff[XLEN] ? {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                  : {diff[XLEN-1:0],   acc[XLEN-2:0], 1'b1};
    assign step_next = f3_q[2] ? div_next : mul_next;

    assign prod_s    = neg_q  ? -step_next : step_next;
    assign quo_s     = neg_q  ? -step_next[XLEN-1:0] : step_next[XLEN-1:0];
    assign rem_s     = rneg_q ? -step_next[2*XLEN-1:XLEN] : step_next[2*XLEN-1:XLEN];
    assign final_res = f3_q[2] ? (f3_q[1] ? rem_s : quo_s)
                     : ((f3_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        stall_e    = 1'b0;
        done_e     = 1'b0;
        case (state)
            IDLE: if (start_e && !flush_e) begin
                stall_e    = rst_n;
                state_next = go_done ? DONE : CALC;
            end
            CALC: begin
                stall_e = rst_n;
                if (flush_e)          state_next = IDLE;
                else if (cnt == LAST) state_next = DONE;
            end
            DONE: begin
                done_e     = ~flush_e;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            acc      <= '0;
            opd_q    <= '0;
            f3_q     <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            result_e <= '0;
        end else begin
            case (state)
                IDLE: if (start_e && !flush_e) begin
                    cnt    <= '0;
                    f3_q   <= funct3_e;
                    neg_q  <= sa ^ sb;
                    rneg_q <= sa;
                    opd_q  <= funct3_e[2] ? mag_b : mag_a;
                    acc    <= {{XLEN{1'b0}}, (funct3_e[2] ? mag_a : mag_b)};
                    if (go_done) result_e <= idle_res;
                end
                CALC: if (!flush_e) begin
                    acc <= step_next;
                    if (cnt == LAST) result_e <= final_res;
                    else             cnt      <= cnt + 5'd1;
                end
                default: ;
            endcase
        end
    end
endmodule
